// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: shift-add multiply and restoring divide feeding the HI/LO pair.
// Latency: mul/div write 34 edges after accept; MTHI/MTLO write one edge after accept.
// Backpressure: one op in flight; op_ready only in IDLE; stall holds decode while busy.
//
// Ports:
//   i_clk, i_reset (synchronous, active-high)
//   i_op_valid/i_op_code/i_rs_data/i_rt_data : request from decode, taken when o_op_ready
//   i_mf_req     : MFHI/MFLO in decode
//   o_op_ready, o_busy, o_stall
//   o_hi_we/o_hi_wdata, o_lo_we/o_lo_wdata : one-cycle HI/LO register writes
//   o_div_by_zero: pulses with the write of a divide whose divisor was zero
// Build option: define HILO_DIV_EN to include the divider datapath. Without it,
// DIV/DIVU spend one cycle in WRITE with no write enables.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_op_valid,
    input  logic [2:0]       i_op_code,
    input  logic [WIDTH-1:0] i_rs_data,
    input  logic [WIDTH-1:0] i_rt_data,
    input  logic             i_mf_req,
    output logic             o_op_ready,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_hi_we,
    output logic             o_lo_we,
    output logic [WIDTH-1:0] o_hi_wdata,
    output logic [WIDTH-1:0] o_lo_wdata,
    output logic             o_div_by_zero
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [2:0]         r_state;
    logic [2:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;   // mul: running product; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_a;     // mul: |multiplicand|; div: |divisor|
    logic               r_neg;   // product / quotient needs negation in FIX
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Signed variants are MULT and DIV (op_code[0] == 0, not a move).
    logic             w_signed, w_rs_neg, w_rt_neg;
    logic [WIDTH-1:0] w_rs_abs, w_rt_abs;
    assign w_signed = ~i_op_code[2] & ~i_op_code[0];
    assign w_rs_neg = w_signed & i_rs_data[WIDTH-1];
    assign w_rt_neg = w_signed & i_rt_data[WIDTH-1];
    assign w_rs_abs = w_rs_neg ? -i_rs_data : i_rs_data;
    assign w_rt_abs = w_rt_neg ? -i_rt_data : i_rt_data;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    logic [WIDTH:0]     w_mul_add, w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next, w_prod_fix;
    assign w_mul_add  = r_acc[0] ? {1'b0, r_a} : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_mul_add;
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod_fix = r_neg ? -r_acc : r_acc;

    logic w_is_mul, w_is_div;
    assign w_is_mul = (r_op == OP_MULT) || (r_op == OP_MULTU);

`ifdef HILO_DIV_EN
    logic [WIDTH-1:0]   r_rs;    // original dividend, returned in HI on divide-by-zero
    logic               r_neg_r; // remainder takes the dividend's sign
    logic               r_dz;
    logic [WIDTH+1:0]   w_div_trial;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

    // Restoring step: trial-subtract divisor from {rem, next dividend bit};
    // keep the difference only when it did not go negative.
    assign w_div_trial = {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {2'b00, r_a};
    assign w_div_ge    = ~w_div_trial[WIDTH+1];
    assign w_div_next  = {(w_div_ge ? w_div_trial[WIDTH-1:0] : r_acc[2*WIDTH-2:WIDTH-1]),
                          r_acc[WIDTH-2:0], w_div_ge};
    assign w_quo_fix   = r_neg   ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
    assign w_rem_fix   = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_is_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign o_div_by_zero = (r_state == S_WRITE) & r_dz;
`else
    assign w_is_div      = 1'b0;
    assign o_div_by_zero = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef HILO_DIV_EN
            r_rs    <= '0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_op_valid) begin
                        r_op  <= i_op_code;
                        r_cnt <= '0;
`ifdef HILO_DIV_EN
                        r_dz  <= 1'b0;
`endif
                        case (i_op_code)
                            OP_MULT, OP_MULTU: begin
                                r_a     <= w_rs_abs;
                                r_acc   <= {{WIDTH{1'b0}}, w_rt_abs};
                                r_neg   <= w_rs_neg ^ w_rt_neg;
                                r_state <= S_MUL;
                            end
`ifdef HILO_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                r_a     <= w_rt_abs;
                                r_acc   <= {{WIDTH{1'b0}}, w_rs_abs};
                                r_neg   <= w_rs_neg ^ w_rt_neg;
                                r_neg_r <= w_rs_neg;
                                r_rs    <= i_rs_data;
                                r_dz    <= (i_rt_data == '0);
                                r_state <= S_DIV;
                            end
`endif
                            OP_MTHI: begin
                                r_hi    <= i_rs_data;
                                r_state <= S_WRITE;
                            end
                            OP_MTLO: begin
                                r_lo    <= i_rs_data;
                                r_state <= S_WRITE;
                            end
                            default: r_state <= S_WRITE;  // no-op codes still take one cycle
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) r_state <= S_FIX;
                end
`ifdef HILO_DIV_EN
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) r_state <= S_FIX;
                end
`endif
                S_FIX: begin
`ifdef HILO_DIV_EN
                    if (w_is_div) begin
                        r_hi <= r_dz ? r_rs : w_rem_fix;
                        r_lo <= r_dz ? '1   : w_quo_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
`else
                    {r_hi, r_lo} <= w_prod_fix;
`endif
                    r_state <= S_WRITE;
                end
                default: r_state <= S_IDLE;  // S_WRITE and any unused encoding
            endcase
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_op_ready = (r_state == S_IDLE);
    assign o_stall    = (i_op_valid | i_mf_req) & o_busy;
    assign o_hi_we    = (r_state == S_WRITE) & (w_is_mul | w_is_div | (r_op == OP_MTHI));
    assign o_lo_we    = (r_state == S_WRITE) & (w_is_mul | w_is_div | (r_op == OP_MTLO));
    assign o_hi_wdata = r_hi;
    assign o_lo_wdata = r_lo;
endmodule
